// File: rtl/usb_pkg.sv
// -----------------------------------------------------------------------------
// usb_pkg
// Shared types and helpers for the FT2232H transmit scheduler.
//   state_e      : scheduler FSM states (TRAILER only with USB_TX_CKSUM_EN)
//   HDR_SYNC_DEFAULT : default upper nibble of every packet header byte
//   make_header  : builds the header byte {sync, channel id}
// Optional feature macro: USB_TX_CKSUM_EN (adds the checksum trailer state).
// -----------------------------------------------------------------------------
package usb_pkg;

    localparam logic [3:0] HDR_SYNC_DEFAULT = 4'hA;

`ifdef USB_TX_CKSUM_EN
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1,
        StTrailer = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1
    } state_e;
`endif

    function automatic logic [7:0] make_header(input logic [3:0] sync, input logic [3:0] id);
        return {sync, id};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter: grants the first requester at or after
// the priority pointer, wrapping around to the lower indices.
// Ports:
//   req   in  NUM_CH  request vector
//   ptr   in  PTR_W   index of the highest-priority channel
//   grant out NUM_CH  one-hot grant, zero when nothing requests
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned PTR_W  = 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant
);

    logic found;

    // Two passes: indices >= ptr first, then the wrapped indices < ptr.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[k] && (k >= int'(ptr))) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && req[k] && (k < int'(ptr))) begin
                grant[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_tx_sched.sv
// -----------------------------------------------------------------------------
// usb_tx_sched
// Packet scheduler in front of the FT2232H synchronous-FIFO write port.
// NUM_CH requesters share the byte-wide write path with round-robin
// arbitration at whole-packet granularity. Each packet is prefixed with a
// header byte {HDR_SYNC, channel id}. A one-byte output register with an
// occupied flag drives wr_n/data and sustains 1 byte/clk while txe_n is low.
// The board-level wrapper builds the data tristate from data_o/data_oe_o.
//
// Optional feature macro: USB_TX_CKSUM_EN -- appends a trailer byte holding
// the XOR of all payload bytes of the packet.
//
// Ports:
//   clk_60mhz_i in  1         FT2232H clock, all logic on rising edge
//   rst_i       in  1         synchronous active-high reset
//   ch_data_i   in  NUM_CH*8  payload byte of channel k at [8k+7:8k]
//   ch_valid_i  in  NUM_CH    per-channel byte valid
//   ch_last_i   in  NUM_CH    per-channel last byte of packet
//   ch_ready_o  out NUM_CH    byte consumed this cycle (combinational)
//   txe_n_i     in  1         FT2232H TX FIFO has space when low
//   wr_n_o      out 1         write strobe, active low, registered
//   data_o      out 8         byte to the FT2232H, registered
//   data_oe_o   out 1         bus drive enable (= !wr_n_o)
//   grant_o     out NUM_CH    one-hot packet owner, zero when idle
//   busy_o      out 1         high while a packet is in progress
// -----------------------------------------------------------------------------
module usb_tx_sched
    import usb_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned MAX_LEN  = 256,
    parameter logic [3:0]  HDR_SYNC = HDR_SYNC_DEFAULT
) (
    input  logic                clk_60mhz_i,
    input  logic                rst_i,
    input  logic [NUM_CH*8-1:0] ch_data_i,
    input  logic [NUM_CH-1:0]   ch_valid_i,
    input  logic [NUM_CH-1:0]   ch_last_i,
    output logic [NUM_CH-1:0]   ch_ready_o,
    input  logic                txe_n_i,
    output logic                wr_n_o,
    output logic [7:0]          data_o,
    output logic                data_oe_o,
    output logic [NUM_CH-1:0]   grant_o,
    output logic                busy_o
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);

    // Registered state
    state_e             state;
    logic               occupied;
    logic [7:0]         out_byte;
    logic [NUM_CH-1:0]  grant;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   count;
`ifdef USB_TX_CKSUM_EN
    logic [7:0]         cksum;
`endif

    // Combinational helpers
    logic               accept;
    logic               free;
    logic [NUM_CH-1:0]  arb_grant;
    logic [3:0]         arb_id;
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic [PTR_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   count_inc;
    logic               load_payload;
    logic               pkt_end;

    // The host takes the byte on an edge where wr_n is low and txe_n is low;
    // the register may be refilled on that same edge.
    assign accept = occupied & ~txe_n_i;
    assign free   = ~occupied | accept;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req    (ch_valid_i),
        .ptr    (ptr),
        .grant  (arb_grant)
    );

    // Header carries the low 4 bits of the winning channel index.
    always_comb begin
        arb_id = 4'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (arb_grant[k]) begin
                arb_id = 4'(k);
            end
        end
    end

    // Mux the current owner's channel signals and its successor index.
    always_comb begin
        sel_data  = 8'd0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        next_ptr  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant[k]) begin
                sel_data  = ch_data_i[8*k +: 8];
                sel_valid = ch_valid_i[k];
                sel_last  = ch_last_i[k];
                next_ptr  = (k == int'(NUM_CH) - 1) ? '0 : PTR_W'(k + 1);
            end
        end
    end

    assign count_inc    = count + CNT_W'(1);
    assign load_payload = (state == StPayload) && sel_valid && free;
    // Forced end when this byte would bring the payload to MAX_LEN.
    assign pkt_end      = sel_last || (count_inc == CNT_W'(MAX_LEN));

    assign ch_ready_o   = ((state == StPayload) && free) ? (grant & ch_valid_i) : '0;

    always_ff @(posedge clk_60mhz_i) begin
        if (rst_i) begin
            state    <= StIdle;
            occupied <= 1'b0;
            out_byte <= 8'd0;
            grant    <= '0;
            ptr      <= '0;
            count    <= '0;
`ifdef USB_TX_CKSUM_EN
            cksum    <= 8'd0;
`endif
        end else begin
            // Drain by default; any load below re-arms the register.
            if (accept) begin
                occupied <= 1'b0;
            end

            case (state)
                StIdle: begin
                    // Header does not consume a payload byte.
                    if ((|ch_valid_i) && free) begin
                        occupied <= 1'b1;
                        out_byte <= make_header(HDR_SYNC, arb_id);
                        grant    <= arb_grant;
                        count    <= '0;
`ifdef USB_TX_CKSUM_EN
                        cksum    <= 8'd0;
`endif
                        state    <= StPayload;
                    end
                end

                StPayload: begin
                    // A stalled requester simply leaves the register empty;
                    // the packet stays open until its end byte arrives.
                    if (load_payload) begin
                        occupied <= 1'b1;
                        out_byte <= sel_data;
                        count    <= count_inc;
`ifdef USB_TX_CKSUM_EN
                        cksum    <= cksum ^ sel_data;
`endif
                        if (pkt_end) begin
                            ptr   <= next_ptr;
`ifdef USB_TX_CKSUM_EN
                            state <= StTrailer;
`else
                            state <= StIdle;
                            grant <= '0;
`endif
                        end
                    end
                end

`ifdef USB_TX_CKSUM_EN
                StTrailer: begin
                    if (free) begin
                        occupied <= 1'b1;
                        out_byte <= cksum;
                        grant    <= '0;
                        state    <= StIdle;
                    end
                end
`endif

                default: begin
                    state <= StIdle;
                    grant <= '0;
                end
            endcase
        end
    end

    assign wr_n_o    = ~occupied;
    assign data_o    = out_byte;
    assign data_oe_o = occupied;
    assign grant_o   = grant;
    assign busy_o    = (state != StIdle);

endmodule

// File: tb/tb_usb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_sched
// Self-checking bench for usb_tx_sched (NUM_CH=2, MAX_LEN=256). Expected bus
// bytes are queued as each packet is scheduled and compared whenever the host
// side accepts a byte. Builds with or without USB_TX_CKSUM_EN.
// -----------------------------------------------------------------------------
module tb_usb_tx_sched;

    localparam int NUM_CH  = 2;
    localparam int MAX_LEN = 256;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_CH*8-1:0] ch_data = '0;
    logic [NUM_CH-1:0]   ch_valid = '0;
    logic [NUM_CH-1:0]   ch_last = '0;
    logic [NUM_CH-1:0]   ch_ready;
    logic                txe_n = 1'b0;
    logic                wr_n;
    logic [7:0]          data;
    logic                data_oe;
    logic [NUM_CH-1:0]   grant;
    logic                busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;
    bit         sb_skip = 1'b0;
    int         cyc = 0;
    int         acc_count = 0;
    int         first_cyc = -1;
    int         last_cyc = -1;

    always #5 clk = ~clk;

    usb_tx_sched #(
        .NUM_CH     (NUM_CH),
        .MAX_LEN    (MAX_LEN),
        .HDR_SYNC   (4'hA)
    ) dut (
        .clk_60mhz_i (clk),
        .rst_i       (rst),
        .ch_data_i   (ch_data),
        .ch_valid_i  (ch_valid),
        .ch_last_i   (ch_last),
        .ch_ready_o  (ch_ready),
        .txe_n_i     (txe_n),
        .wr_n_o      (wr_n),
        .data_o      (data),
        .data_oe_o   (data_oe),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Host side: a byte is taken on the coming edge when wr_n and txe_n are low.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            #2;
            if (!rst && !wr_n && !txe_n && !sb_skip) begin
                acc_count++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("bus_byte", 32'(data), 32'(mon_exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Queue header, payload and (if enabled and the packet ends) the XOR trailer.
    task automatic push_pkt(input logic [7:0] hdr, input int n, input logic [7:0] base,
                            input bit ends);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        exp_q.push_back(hdr);
        for (int i = 0; i < n; i++) begin
            b = base + 8'(i);
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef USB_TX_CKSUM_EN
        if (ends) exp_q.push_back(x);
`else
        if (ends) x = 8'd0;
`endif
    endtask

    // Offer n bytes base+i on channel ch; optional valid gap before byte gap_at.
    task automatic send(input int ch, input int n, input logic [7:0] base, input bit with_last,
                        input int gap_at, input int gap_len, input bit release_end);
        for (int i = 0; i < n; i++) begin
            bit done;
            int budget;
            done   = 1'b0;
            budget = 0;
            if (i == gap_at) begin
                @(negedge clk);
                ch_valid[ch] = 1'b0;
                ch_last[ch]  = 1'b0;
                repeat (gap_len - 1) @(negedge clk);
            end
            while (!done) begin
                @(negedge clk);
                ch_data[8*ch +: 8] = base + 8'(i);
                ch_valid[ch]       = 1'b1;
                ch_last[ch]        = with_last && (i == n - 1);
                #1;
                if (ch_ready[ch]) begin
                    done = 1'b1;
                end else if (++budget > 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: ch %0d byte %0d got no ready, expected ready",
                             ch, i);
                    ch_valid[ch] = 1'b0;
                    return;
                end
            end
        end
        if (release_end) begin
            @(negedge clk);
            ch_valid[ch] = 1'b0;
            ch_last[ch]  = 1'b0;
        end
    endtask

    task automatic check_grant(input logic [NUM_CH-1:0] exp, input string name);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #1;
            if (busy) break;
        end
        check(name, 32'(grant), 32'(exp));
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && wr_n) break;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        ch_valid = '0;
        ch_last  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int               ch;
        int               len;
        logic [7:0]       base;
        logic [7:0]       exp_hdr;
        logic [NUM_CH-1:0] exp_grant;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] held_data;
    int gap_cycles;
    int grant_bad;

    initial begin
        tbl[0] = '{ch: 0, len: 1, base: 8'h10, exp_hdr: 8'hA0, exp_grant: 2'b01};
        tbl[1] = '{ch: 1, len: 4, base: 8'h20, exp_hdr: 8'hA1, exp_grant: 2'b10};
        tbl[2] = '{ch: 1, len: 2, base: 8'h30, exp_hdr: 8'hA1, exp_grant: 2'b10};
        tbl[3] = '{ch: 0, len: 5, base: 8'h40, exp_hdr: 8'hA0, exp_grant: 2'b01};
        tbl[4] = '{ch: 1, len: 1, base: 8'hF0, exp_hdr: 8'hA1, exp_grant: 2'b10};

        // Reset values, with requests present during reset.
        rst      = 1'b1;
        ch_valid = 2'b11;
        txe_n    = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_wr_n", 32'(wr_n), 32'd1);
        check("rst_data", 32'(data), 32'd0);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(ch_ready), 32'd0);
        ch_valid = '0;
        rst      = 1'b0;

        // Latency and byte sequence for a 3-byte packet on ch0.
        push_pkt(8'hA0, 3, 8'h11, 1'b0);
        exp_q.delete();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
`ifdef USB_TX_CKSUM_EN
        exp_q.push_back(8'h00);
`endif
        @(negedge clk);
        ch_data[7:0] = 8'h11;
        ch_valid[0]  = 1'b1;
        ch_last[0]   = 1'b0;
        #1;
        check("idle_ready", 32'(ch_ready), 32'd0);
        check("idle_wr_n", 32'(wr_n), 32'd1);
        @(negedge clk);
        #1;
        check("hdr_wr_n", 32'(wr_n), 32'd0);
        check("hdr_data", 32'(data), 32'hA0);
        check("hdr_grant", 32'(grant), 32'd1);
        check("hdr_busy", 32'(busy), 32'd1);
        check("pay_ready", 32'(ch_ready), 32'd1);
        @(negedge clk);
        ch_data[7:0] = 8'h22;
        #1;
        check("c2_data", 32'(data), 32'h11);
        @(negedge clk);
        ch_data[7:0] = 8'h33;
        ch_last[0]   = 1'b1;
        #1;
        check("c3_data", 32'(data), 32'h22);
        @(negedge clk);
        ch_valid[0] = 1'b0;
        ch_last[0]  = 1'b0;
        #1;
        check("c4_data", 32'(data), 32'h33);
        check("c4_wr_n", 32'(wr_n), 32'd0);
        @(negedge clk);
        #1;
`ifdef USB_TX_CKSUM_EN
        check("c5_trailer_wr_n", 32'(wr_n), 32'd0);
        check("c5_trailer_data", 32'(data), 32'h00);
`else
        check("c5_wr_n", 32'(wr_n), 32'd1);
`endif
        wait_drain("drain_basic");

        // Table of single-channel packets (lone requesters, back-to-back wins).
        for (int i = 0; i < 5; i++) begin
            push_pkt(tbl[i].exp_hdr, tbl[i].len, tbl[i].base, 1'b1);
            fork
                send(tbl[i].ch, tbl[i].len, tbl[i].base, 1'b1, -1, 0, 1'b1);
                check_grant(tbl[i].exp_grant, "tbl_grant");
            join
            wait_drain("tbl_drain");
        end

        // Both channels continuously valid: alternating packets, no gaps.
        push_pkt(8'hA0, 2, 8'h00, 1'b1);
        push_pkt(8'hA1, 2, 8'h80, 1'b1);
        push_pkt(8'hA0, 2, 8'h02, 1'b1);
        push_pkt(8'hA1, 2, 8'h82, 1'b1);
        acc_count = 0;
        first_cyc = -1;
        last_cyc  = -1;
        fork
            begin
                send(0, 2, 8'h00, 1'b1, -1, 0, 1'b0);
                send(0, 2, 8'h02, 1'b1, -1, 0, 1'b1);
            end
            begin
                send(1, 2, 8'h80, 1'b1, -1, 0, 1'b0);
                send(1, 2, 8'h82, 1'b1, -1, 0, 1'b1);
            end
        join
        wait_drain("rr_drain");
`ifdef USB_TX_CKSUM_EN
        check("rr_byte_count", 32'(acc_count), 32'd16);
`else
        check("rr_byte_count", 32'(acc_count), 32'd12);
`endif
        check("rr_nogap_span", 32'(last_cyc - first_cyc + 1), 32'(acc_count));

        // Back-pressure: txe_n high for 4 cycles mid-payload.
        push_pkt(8'hA0, 8, 8'h50, 1'b1);
        fork
            send(0, 8, 8'h50, 1'b1, -1, 0, 1'b1);
            begin
                repeat (5) @(negedge clk);
                txe_n = 1'b1;
                #1;
                held_data = data;
                for (int c = 0; c < 4; c++) begin
                    if (c > 0) begin
                        @(negedge clk);
                        #1;
                    end
                    check("stall_data", 32'(data), 32'(held_data));
                    check("stall_wr_n", 32'(wr_n), 32'd0);
                    check("stall_ready", 32'(ch_ready), 32'd0);
                end
                @(negedge clk);
                txe_n = 1'b0;
            end
        join
        wait_drain("stall_drain");

        // Requester valid drops for 3 cycles mid-packet.
        push_pkt(8'hA0, 6, 8'h60, 1'b1);
        gap_cycles = 0;
        grant_bad  = 0;
        fork
            send(0, 6, 8'h60, 1'b1, 3, 3, 1'b1);
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    #1;
                    if (busy) break;
                end
                for (int c = 0; c < 200 && busy; c++) begin
                    if (wr_n) gap_cycles++;
                    if (grant !== 2'b01) grant_bad++;
                    @(negedge clk);
                    #1;
                end
            end
        join
        wait_drain("gap_drain");
        check("gap_cycles", 32'(gap_cycles), 32'd3);
        check("gap_grant_held", 32'(grant_bad), 32'd0);

        // MAX_LEN forced end: 300 bytes without last on ch1.
        push_pkt(8'hA1, 256, 8'h00, 1'b1);
        push_pkt(8'hA1, 44, 8'h00, 1'b0);
        send(1, 300, 8'h00, 1'b0, -1, 0, 1'b1);
        wait_drain("maxlen_drain");
        check("maxlen_open_busy", 32'(busy), 32'd1);
        check("maxlen_open_grant", 32'(grant), 32'd2);
        do_reset();

        // Reset mid-packet on ch1 after moving the pointer to ch1.
        push_pkt(8'hA0, 1, 8'h77, 1'b1);
        send(0, 1, 8'h77, 1'b1, -1, 0, 1'b1);
        wait_drain("pre_rst_drain");
        sb_skip = 1'b1;
        @(negedge clk);
        ch_data[15:8] = 8'h55;
        ch_valid[1]   = 1'b1;
        repeat (4) @(negedge clk);
        rst      = 1'b1;
        ch_valid = '0;
        @(negedge clk);
        #1;
        check("midrst_wr_n", 32'(wr_n), 32'd1);
        check("midrst_grant", 32'(grant), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_data", 32'(data), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        sb_skip = 1'b0;
        push_pkt(8'hA0, 1, 8'h01, 1'b1);
        push_pkt(8'hA1, 1, 8'h02, 1'b1);
        fork
            send(0, 1, 8'h01, 1'b1, -1, 0, 1'b1);
            send(1, 1, 8'h02, 1'b1, -1, 0, 1'b1);
            check_grant(2'b01, "post_rst_grant");
        join
        wait_drain("post_rst_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
